// File: rtl/button_mmio.sv
// button_mmio: memory-mapped push-button peripheral between the processor
// data-memory port and RAM.
//
// Each of NUM_BTN channels runs a two-flop synchroniser and a debouncer. A
// debounced 0->1 transition is a press: it sets a sticky PRESS bit and bumps
// a saturating 16-bit press counter (once per edge, however many channels
// pressed on that edge).
//
// Register window (word addresses BASE_ADDR .. BASE_ADDR+3):
//   +0 LEVEL  debounced levels, read-only
//   +1 PRESS  sticky press flags, write-1-to-clear (a new press beats the clear)
//   +2 COUNT  saturating press counter, any write clears (the write beats a press)
//   +3 MASK   interrupt enables (only with BUTTON_MMIO_IRQ_EN, else reads 0)
// Accesses inside the window are served here and never reach RAM. All other
// addresses pass through unchanged.
//
// Build option: define BUTTON_MMIO_IRQ_EN to compile in the MASK register and
// the registered irq = |(PRESS & MASK). Without it, irq is tied to 0.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   btn_raw       raw asynchronous buttons, 1 = pressed
//   address_dmem  processor word address
//   wren          processor write enable
//   data          processor write data
//   q_ram         RAM read data
//   q_dmem        read data to processor (combinational mux)
//   ram_wren      write enable forwarded to RAM
//   irq           level interrupt request

// One button channel: synchroniser, debounce counter, stable level.
// press is the combinational strobe for the edge on which the stable level
// is about to go 0->1, so the top can set PRESS on that same edge.
module button_mmio_chan #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_ff;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          sync;
    logic          accept;

    assign sync   = sync_ff[1];
    // The synchronised input has disagreed with stable for DEBOUNCE_CYCLES
    // consecutive edges (counting this one): take the new level now.
    assign accept = (sync != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_ff <= '0;
            cnt     <= '0;
            stable  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], btn_raw};
            if (sync == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = stable;
    assign press = accept & sync;
endmodule

module button_mmio #(
    parameter int          NUM_BTN         = 4,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR       = 32'd1000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [31:0]        address_dmem,
    input  logic               wren,
    input  logic [31:0]        data,
    input  logic [31:0]        q_ram,
    output logic [31:0]        q_dmem,
    output logic               ram_wren,
    output logic               irq
);
    typedef struct packed {
        logic       hit;
        logic [1:0] offset;
        logic       wr;
    } bus_req_t;

    bus_req_t           req;
    logic [31:0]        rel_addr;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press_evt;
    logic [NUM_BTN-1:0] wdata_btn;
    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] press_nxt;
    logic [15:0]        count_q;
    logic [15:0]        count_nxt;
    logic               wr_press;
    logic               wr_count;
    logic               wr_mask;
    logic [31:0]        mask_rd;
    logic [31:0]        reg_rd;
    logic               unused_data;

    // Unsigned offset from the base: addresses below BASE_ADDR wrap to large
    // values, so a single compare covers both ends of the window.
    assign rel_addr = address_dmem - BASE_ADDR;

    always_comb begin
        req.hit    = (rel_addr < 32'd4);
        req.offset = rel_addr[1:0];
        req.wr     = wren & req.hit;
    end

    assign ram_wren  = wren & ~req.hit;
    assign wdata_btn = data[NUM_BTN-1:0];
    assign wr_press  = req.wr && (req.offset == 2'd1);
    assign wr_count  = req.wr && (req.offset == 2'd2);
    assign wr_mask   = req.wr && (req.offset == 2'd3);
    // Write data above NUM_BTN is dropped by design.
    assign unused_data = ^data;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_mmio_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .btn_raw(btn_raw[i]),
            .level  (level[i]),
            .press  (press_evt[i])
        );
    end

    always_comb begin
        // Clear first, then OR in new presses so a press beats the W1C.
        press_nxt = press_q;
        if (wr_press) press_nxt = press_nxt & ~wdata_btn;
        press_nxt = press_nxt | press_evt;

        // A write beats a same-edge increment.
        count_nxt = count_q;
        if (wr_count) begin
            count_nxt = '0;
        end else if ((|press_evt) && (count_q != 16'hFFFF)) begin
            count_nxt = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            press_q <= '0;
            count_q <= '0;
        end else begin
            press_q <= press_nxt;
            count_q <= count_nxt;
        end
    end

`ifdef BUTTON_MMIO_IRQ_EN
    logic [NUM_BTN-1:0] mask_q;
    logic [NUM_BTN-1:0] mask_nxt;
    logic               irq_q;

    assign mask_nxt = wr_mask ? wdata_btn : mask_q;

    // Built from the next-state values so irq matches PRESS/MASK as they
    // stand after every edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_nxt;
            irq_q  <= |(press_nxt & mask_nxt);
        end
    end

    assign irq     = irq_q;
    assign mask_rd = 32'(mask_q);
`else
    logic unused_mask_wr;

    // Offset 3 is still decoded (kept off RAM) but has no storage.
    assign unused_mask_wr = wr_mask;
    assign irq            = 1'b0;
    assign mask_rd        = '0;
`endif

    always_comb begin
        reg_rd = '0;
        case (req.offset)
            2'd0:    reg_rd = 32'(level);
            2'd1:    reg_rd = 32'(press_q);
            2'd2:    reg_rd = 32'(count_q);
            default: reg_rd = mask_rd;
        endcase
        q_dmem = req.hit ? reg_rd : q_ram;
    end
endmodule
